// File: rtl/smi_mem_lib_write_burst_sched.sv
// Splits one write transfer into bursts that never cross a MaxBurstBytes boundary,
// with bounded outstanding bursts. Optional macro SMI_WRITE_SCHED_ERR_ABORT_EN stops issuing after the first failed burst.
module smi_mem_lib_write_burst_sched #(
  parameter int MaxBurstBytes  = 2048,
  parameter int MaxOutstanding = 4
) (
  input  logic        clk,
  input  logic        srst,
  input  logic        xferValid,
  input  logic [63:0] xferAddr,
  input  logic [31:0] xferLen,
  input  logic [7:0]  xferOpts,
  output logic        xferStop,
  output logic        burstValid,
  output logic [63:0] burstAddr,
  output logic [15:0] burstLen,
  output logic [7:0]  burstOpts,
  input  logic        burstStop,
  input  logic        burstDoneValid,
  input  logic        burstDoneStatusOk,
  output logic        burstDoneStop,
  output logic        xferDoneValid,
  output logic        xferDoneStatusOk,
  input  logic        xferDoneStop
);

  localparam int OFF_W = $clog2(MaxBurstBytes);
  localparam int OUT_W = $clog2(MaxOutstanding + 1);
  localparam logic [OUT_W-1:0] MAX_OUT    = OUT_W'(MaxOutstanding);
  localparam logic [OFF_W:0]   BURST_SPAN = (OFF_W+1)'(MaxBurstBytes);

`ifdef SMI_WRITE_SCHED_ERR_ABORT_EN
  localparam bit ABORT_EN = 1'b1;
`else
  localparam bit ABORT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_REPORT} state_t;

  state_t           state_q, state_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             status_ok_q, status_ok_d;
  logic [63:0]      addr_q, addr_d;
  logic [31:0]      rem_q, rem_d;
  logic [7:0]       opts_q, opts_d;

  logic [OFF_W:0]   room;
  logic [15:0]      burst_len;
  logic             burst_valid;
  logic             burst_done_stop;
  logic             burst_hs;
  logic             done_hs;

  // Saturate the remaining byte count to the room left before the next burst boundary.
  function automatic logic [15:0] clamp_len(input logic [31:0] rem, input logic [OFF_W:0] rm);
    if (rem < 32'(rm)) clamp_len = rem[15:0];
    else               clamp_len = 16'(rm);
  endfunction

  always_comb begin
    room            = BURST_SPAN - {1'b0, addr_q[OFF_W-1:0]};
    burst_len       = clamp_len(rem_q, room);
    burst_valid     = (state_q == ST_ISSUE) && (rem_q != '0) && (out_q < MAX_OUT) &&
                      (!ABORT_EN || status_ok_q);
    burst_done_stop = (out_q == '0);
    burst_hs        = burst_valid && !burstStop;
    done_hs         = burstDoneValid && !burst_done_stop;
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    status_ok_d = status_ok_q;
    addr_d      = addr_q;
    rem_d       = rem_q;
    opts_d      = opts_q;
    case (state_q)
      ST_IDLE: begin
        if (xferValid) begin
          addr_d      = xferAddr;
          rem_d       = xferLen;
          opts_d      = xferOpts;
          status_ok_d = 1'b1;
          out_d       = '0;
          state_d     = (xferLen == '0) ? ST_REPORT : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (burst_hs) begin
          addr_d = addr_q + 64'(burst_len);
          rem_d  = rem_q - 32'(burst_len);
        end
        // Issue and completion in the same cycle cancel in the counter.
        out_d = out_q + OUT_W'(burst_hs) - OUT_W'(done_hs);
        if (done_hs) status_ok_d = status_ok_q & burstDoneStatusOk;
        if ((out_d == '0) && ((rem_d == '0) || (ABORT_EN && !status_ok_d)))
          state_d = ST_REPORT;
      end
      ST_REPORT: begin
        if (!xferDoneStop) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      state_q     <= ST_IDLE;
      out_q       <= '0;
      status_ok_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      status_ok_q <= status_ok_d;
    end
  end

  // Transfer bookkeeping needs no reset: it is loaded on every accept.
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    rem_q  <= rem_d;
    opts_q <= opts_d;
  end

  assign xferStop         = (state_q != ST_IDLE);
  assign burstValid       = burst_valid;
  assign burstAddr        = addr_q;
  assign burstLen         = burst_len;
  assign burstOpts        = opts_q;
  assign burstDoneStop    = burst_done_stop;
  assign xferDoneValid    = (state_q == ST_REPORT);
  assign xferDoneStatusOk = (state_q == ST_REPORT) && status_ok_q;

endmodule

// File: tb/tb_smi_mem_lib_write_burst_sched.sv
// Directed testbench for smi_mem_lib_write_burst_sched (MaxBurstBytes=2048, MaxOutstanding=4).
module tb_smi_mem_lib_write_burst_sched;
  logic        clk = 1'b0;
  logic        srst = 1'b1;
  logic        xferValid = 1'b0;
  logic [63:0] xferAddr = '0;
  logic [31:0] xferLen = '0;
  logic [7:0]  xferOpts = '0;
  logic        xferStop;
  logic        burstValid;
  logic [63:0] burstAddr;
  logic [15:0] burstLen;
  logic [7:0]  burstOpts;
  logic        burstStop = 1'b0;
  logic        burstDoneValid = 1'b0;
  logic        burstDoneStatusOk = 1'b1;
  logic        burstDoneStop;
  logic        xferDoneValid;
  logic        xferDoneStatusOk;
  logic        xferDoneStop = 1'b0;

  int total = 0;
  int bad = 0;

  smi_mem_lib_write_burst_sched #(.MaxBurstBytes(2048), .MaxOutstanding(4)) dut (
    .clk(clk), .srst(srst),
    .xferValid(xferValid), .xferAddr(xferAddr), .xferLen(xferLen), .xferOpts(xferOpts),
    .xferStop(xferStop),
    .burstValid(burstValid), .burstAddr(burstAddr), .burstLen(burstLen), .burstOpts(burstOpts),
    .burstStop(burstStop),
    .burstDoneValid(burstDoneValid), .burstDoneStatusOk(burstDoneStatusOk),
    .burstDoneStop(burstDoneStop),
    .xferDoneValid(xferDoneValid), .xferDoneStatusOk(xferDoneStatusOk),
    .xferDoneStop(xferDoneStop)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a transfer in Idle for one cycle; leaves the bench in the following cycle.
  task automatic accept(input logic [63:0] a, input logic [31:0] l, input logic [7:0] o);
    xferAddr = a; xferLen = l; xferOpts = o; xferValid = 1'b1;
    #1;
    total++; if (xferStop !== 1'b0) begin bad++; $display("FAIL accept_xferStop got=%0b exp=0", xferStop); end
    tick();
    xferValid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    tick(); tick();
    total++; if (xferStop !== 1'b0) begin bad++; $display("FAIL rst_xferStop got=%0b exp=0", xferStop); end
    total++; if (burstValid !== 1'b0) begin bad++; $display("FAIL rst_burstValid got=%0b exp=0", burstValid); end
    total++; if (burstDoneStop !== 1'b1) begin bad++; $display("FAIL rst_burstDoneStop got=%0b exp=1", burstDoneStop); end
    total++; if (xferDoneValid !== 1'b0) begin bad++; $display("FAIL rst_xferDoneValid got=%0b exp=0", xferDoneValid); end
    total++; if (xferDoneStatusOk !== 1'b0) begin bad++; $display("FAIL rst_xferDoneStatusOk got=%0b exp=0", xferDoneStatusOk); end
    srst = 1'b0;
    tick();
    total++; if (xferStop !== 1'b0 || burstValid !== 1'b0) begin bad++; $display("FAIL rst_release got=%0b%0b exp=00", xferStop, burstValid); end
  endtask

  task automatic test_aligned_split();
    accept(64'h1000, 32'd4096, 8'h00);
    total++; if (burstValid !== 1'b1 || xferStop !== 1'b1) begin bad++; $display("FAIL al_first_valid got=%0b%0b exp=11", burstValid, xferStop); end
    total++; if (burstAddr !== 64'h1000 || burstLen !== 16'd2048) begin bad++; $display("FAIL al_burst0 got=%0h/%0d exp=1000/2048", burstAddr, burstLen); end
    tick();
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h1800 || burstLen !== 16'd2048) begin bad++; $display("FAIL al_burst1 got=%0b %0h/%0d exp=1 1800/2048", burstValid, burstAddr, burstLen); end
    tick();
    total++; if (burstValid !== 1'b0 || burstDoneStop !== 1'b0) begin bad++; $display("FAIL al_after_issue got=%0b%0b exp=00", burstValid, burstDoneStop); end
    burstDoneValid = 1'b1; burstDoneStatusOk = 1'b1;
    tick();
    total++; if (xferDoneValid !== 1'b0) begin bad++; $display("FAIL al_early_done got=%0b exp=0", xferDoneValid); end
    tick();
    burstDoneValid = 1'b0;
    #1;
    total++; if (xferDoneValid !== 1'b1 || xferDoneStatusOk !== 1'b1) begin bad++; $display("FAIL al_done got=%0b%0b exp=11", xferDoneValid, xferDoneStatusOk); end
    tick();
    total++; if (xferDoneValid !== 1'b0 || xferStop !== 1'b0) begin bad++; $display("FAIL al_back_idle got=%0b%0b exp=00", xferDoneValid, xferStop); end
  endtask

  task automatic test_unaligned();
    accept(64'h17F8, 32'd24, 8'h01);
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h17F8 || burstLen !== 16'd8 || burstOpts !== 8'h01) begin bad++; $display("FAIL ua_burst0 got=%0b %0h/%0d/%0h exp=1 17f8/8/1", burstValid, burstAddr, burstLen, burstOpts); end
    tick();
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h1800 || burstLen !== 16'd16 || burstOpts !== 8'h01) begin bad++; $display("FAIL ua_burst1 got=%0b %0h/%0d/%0h exp=1 1800/16/1", burstValid, burstAddr, burstLen, burstOpts); end
    tick();
    total++; if (burstValid !== 1'b0) begin bad++; $display("FAIL ua_no_third got=%0b exp=0", burstValid); end
    burstDoneValid = 1'b1;
    tick(); tick();
    burstDoneValid = 1'b0;
    #1;
    total++; if (xferDoneValid !== 1'b1 || xferDoneStatusOk !== 1'b1) begin bad++; $display("FAIL ua_done got=%0b%0b exp=11", xferDoneValid, xferDoneStatusOk); end
    tick();
  endtask

  task automatic test_zero_len();
    accept(64'h2000, 32'd0, 8'h00);
    total++; if (burstValid !== 1'b0) begin bad++; $display("FAIL zl_burstValid got=%0b exp=0", burstValid); end
    total++; if (xferDoneValid !== 1'b1 || xferDoneStatusOk !== 1'b1) begin bad++; $display("FAIL zl_done got=%0b%0b exp=11", xferDoneValid, xferDoneStatusOk); end
    tick();
    total++; if (xferDoneValid !== 1'b0) begin bad++; $display("FAIL zl_idle got=%0b exp=0", xferDoneValid); end
  endtask

  task automatic test_outstanding_limit();
    int n;
    bit seen;
    accept(64'h0, 32'd16384, 8'h00);
    for (int i = 0; i < 4; i++) begin
      total++; if (burstValid !== 1'b1 || burstAddr !== 64'(i * 2048)) begin bad++; $display("FAIL ol_issue%0d got=%0b %0h exp=1 %0h", i, burstValid, burstAddr, i * 2048); end
      tick();
    end
    total++; if (burstValid !== 1'b0) begin bad++; $display("FAIL ol_limit got=%0b exp=0", burstValid); end
    tick(); tick();
    total++; if (burstValid !== 1'b0) begin bad++; $display("FAIL ol_limit_hold got=%0b exp=0", burstValid); end
    burstDoneValid = 1'b1;
    tick();
    burstDoneValid = 1'b0;
    #1;
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h2000 || burstLen !== 16'd2048) begin bad++; $display("FAIL ol_fifth got=%0b %0h/%0d exp=1 2000/2048", burstValid, burstAddr, burstLen); end
    // Issue and completion together: the counter stays at 3 so another burst follows.
    burstDoneValid = 1'b1;
    tick();
    burstDoneValid = 1'b0;
    #1;
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h2800) begin bad++; $display("FAIL ol_coincide got=%0b %0h exp=1 2800", burstValid, burstAddr); end
    tick();
    total++; if (burstValid !== 1'b0) begin bad++; $display("FAIL ol_relimit got=%0b exp=0", burstValid); end
    burstDoneValid = 1'b1;
    n = 0; seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (xferDoneValid) begin seen = 1'b1; break; end
      if (burstValid) n++;
      tick();
    end
    burstDoneValid = 1'b0;
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL ol_timeout got=%0b exp=1", seen); end
    total++; if (n != 2) begin bad++; $display("FAIL ol_tail_bursts got=%0d exp=2", n); end
    total++; if (xferDoneStatusOk !== 1'b1) begin bad++; $display("FAIL ol_status got=%0b exp=1", xferDoneStatusOk); end
    tick();
  endtask

  task automatic test_error();
    xferDoneStop = 1'b1;
    burstStop = 1'b1;
    accept(64'h0, 32'd6144, 8'h00);
    burstStop = 1'b0;
    #1;
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h0) begin bad++; $display("FAIL er_b0 got=%0b %0h exp=1 0", burstValid, burstAddr); end
    tick();
    burstStop = 1'b1; burstDoneValid = 1'b1; burstDoneStatusOk = 1'b1;
    tick();
    burstDoneValid = 1'b0; burstStop = 1'b0;
    #1;
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h800) begin bad++; $display("FAIL er_b1 got=%0b %0h exp=1 800", burstValid, burstAddr); end
    tick();
    burstStop = 1'b1; burstDoneValid = 1'b1; burstDoneStatusOk = 1'b0;
    tick();
    burstDoneValid = 1'b0; burstDoneStatusOk = 1'b1;
    #1;
`ifdef SMI_WRITE_SCHED_ERR_ABORT_EN
    total++; if (burstValid !== 1'b0) begin bad++; $display("FAIL er_abort_valid got=%0b exp=0", burstValid); end
`else
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h1000 || burstLen !== 16'd2048) begin bad++; $display("FAIL er_b2 got=%0b %0h/%0d exp=1 1000/2048", burstValid, burstAddr, burstLen); end
    total++; if (xferDoneValid !== 1'b0) begin bad++; $display("FAIL er_early_done got=%0b exp=0", xferDoneValid); end
    burstStop = 1'b0;
    tick();
    burstStop = 1'b1; burstDoneValid = 1'b1;
    tick();
    burstDoneValid = 1'b0; burstStop = 1'b0;
    #1;
`endif
    for (int i = 0; i < 5; i++) begin
      total++; if (xferDoneValid !== 1'b1 || xferDoneStatusOk !== 1'b0) begin bad++; $display("FAIL er_hold%0d got=%0b%0b exp=10", i, xferDoneValid, xferDoneStatusOk); end
      tick();
    end
    xferDoneStop = 1'b0;
    tick();
    total++; if (xferDoneValid !== 1'b0 || xferStop !== 1'b0) begin bad++; $display("FAIL er_release got=%0b%0b exp=00", xferDoneValid, xferStop); end
  endtask

  task automatic test_reset_mid();
    accept(64'h0, 32'd8192, 8'h00);
    tick(); tick();
    total++; if (burstValid !== 1'b1 || burstDoneStop !== 1'b0) begin bad++; $display("FAIL rm_pre got=%0b%0b exp=10", burstValid, burstDoneStop); end
    #2;
    srst = 1'b1;
    #1;
    total++; if (xferStop !== 1'b0 || burstValid !== 1'b0 || burstDoneStop !== 1'b1 || xferDoneValid !== 1'b0 || xferDoneStatusOk !== 1'b0) begin
      bad++; $display("FAIL rm_async got=%0b%0b%0b%0b%0b exp=00100", xferStop, burstValid, burstDoneStop, xferDoneValid, xferDoneStatusOk);
    end
    tick();
    srst = 1'b0;
    tick();
    accept(64'h40, 32'd16, 8'h5A);
    total++; if (burstValid !== 1'b1 || burstAddr !== 64'h40 || burstLen !== 16'd16 || burstOpts !== 8'h5A) begin bad++; $display("FAIL rm_post got=%0b %0h/%0d/%0h exp=1 40/16/5a", burstValid, burstAddr, burstLen, burstOpts); end
    tick();
    burstDoneValid = 1'b1;
    tick();
    burstDoneValid = 1'b0;
    #1;
    total++; if (xferDoneValid !== 1'b1 || xferDoneStatusOk !== 1'b1) begin bad++; $display("FAIL rm_done got=%0b%0b exp=11", xferDoneValid, xferDoneStatusOk); end
    tick();
  endtask

  initial begin
    test_reset();
    test_aligned_split();
    test_unaligned();
    test_zero_len();
    test_outstanding_limit();
    test_error();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
